// File: rtl/dma_pkt_pkg.sv
// Packet geometry and receive FSM states shared by the DMA bridge packer and unpacker.
package dma_pkt_pkg;

  localparam int PKT_W     = 4072;
  localparam int PAYLOAD_W = 4064;
  localparam int SEQ_W     = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } state_t;

endpackage

// File: rtl/data_unpack_if.sv
// Host stream in, DUT-side payload out. The master is the host/consumer side, the slave is the unpacker.
interface data_unpack_if
  import dma_pkt_pkg::*;
#(
  parameter int BEAT_W = 512
);

  logic [BEAT_W-1:0]    s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tlast;
  logic                 s_axis_tready;
  logic [PAYLOAD_W-1:0] in_io_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, in_ready,
    input  s_axis_tready, in_io_data, in_valid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, in_ready,
    output s_axis_tready, in_io_data, in_valid
  );

endinterface

// File: rtl/dp_beat_assembler.sv
// Beat index counter and packet register; beat k lands at packet bits [k*BEAT_W +: BEAT_W],
// truncated at PKT_W. Flags a tlast that disagrees with the last-beat position.
module dp_beat_assembler
  import dma_pkt_pkg::*;
#(
  parameter int BEAT_W = 512,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [BEAT_W-1:0] tdata,
  input  logic              tlast,
  output logic [PKT_W-1:0]  pkt,
  output logic              last_idx,
  output logic              tlast_mismatch
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [IDX_W-1:0] idx_q;

  assign last_idx       = (idx_q == IDX_W'(BEATS - 1));
  assign tlast_mismatch = wr && (tlast != last_idx);

  // Any tlast or the final beat closes the frame, good or bad, so the next beat starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (wr) begin
      if (tlast || last_idx) idx_q <= '0;
      else                   idx_q <= idx_q + IDX_W'(1);
    end
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    localparam int LO = b * BEAT_W;
    localparam int W  = ((PKT_W - LO) < BEAT_W) ? (PKT_W - LO) : BEAT_W;
    if (W > 0) begin : g_seg
      logic [W-1:0] seg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_q <= '0;
        end else if (clr) begin
          seg_q <= '0;
        end else if (wr && (idx_q == IDX_W'(b))) begin
          seg_q <= tdata[W-1:0];
        end
      end
      assign pkt[LO +: W] = seg_q;
    end
  end

endmodule

// File: rtl/data_unpack.sv
// Host-to-card receive unpacker: assembles packets from the stream, checks sequence, hands off payload.
// Optional sequence checking is built when DATA_UNPACK_SEQ_CHECK_EN is defined.
module data_unpack
  import dma_pkt_pkg::*;
#(
  parameter int BEAT_W = 512,
  parameter int BEATS  = 8
) (
  input  logic             m_axis_c2h_aclk,
  input  logic             m_axis_c2h_aresetn,
  input  logic             en,
  data_unpack_if.slave     bus,
  output logic [SEQ_W-1:0] rx_num_wire,
  output logic             seq_err,
  output logic [7:0]       frame_err_cnt
);

  state_t           state_q, state_d;
  logic             acc, wr, pkt_done;
  logic             last_idx, tlast_mismatch;
  logic [PKT_W-1:0] pkt;
  logic [SEQ_W-1:0] rx_seq;

  assign bus.s_axis_tready = (state_q != HOLD);
  assign bus.in_valid      = (state_q == HOLD);
  assign bus.in_io_data    = pkt[PKT_W-1:SEQ_W];

  assign acc      = bus.s_axis_tvalid && bus.s_axis_tready;
  assign wr       = acc && (state_q == COLLECT) && !en;
  assign pkt_done = wr && last_idx && bus.s_axis_tlast;
  assign rx_seq   = pkt[SEQ_W-1:0];

  dp_beat_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_asm (
    .clk            (m_axis_c2h_aclk),
    .rst_n          (m_axis_c2h_aresetn),
    .clr            (en),
    .wr             (wr),
    .tdata          (bus.s_axis_tdata),
    .tlast          (bus.s_axis_tlast),
    .pkt            (pkt),
    .last_idx       (last_idx),
    .tlast_mismatch (tlast_mismatch)
  );

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) state_q <= COLLECT;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (pkt_done)                                    state_d = HOLD;
        else if (tlast_mismatch && !bus.s_axis_tlast)    state_d = DROP;
      end
      HOLD:    if (bus.in_ready)                         state_d = COLLECT;
      DROP:    if (acc && bus.s_axis_tlast)              state_d = COLLECT;
      default:                                           state_d = COLLECT;
    endcase
    if (en) state_d = COLLECT;
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      frame_err_cnt <= '0;
      rx_num_wire   <= '0;
    end else if (en) begin
      frame_err_cnt <= '0;
      rx_num_wire   <= '0;
    end else begin
      if (tlast_mismatch && (frame_err_cnt != 8'hFF)) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (pkt_done)                                    rx_num_wire   <= rx_seq;
    end
  end

`ifdef DATA_UNPACK_SEQ_CHECK_EN
  logic [SEQ_W-1:0] expected_q;
  logic             seq_err_q;

  // Resync on mismatch: the next packet is judged against the one just received.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      expected_q <= '0;
      seq_err_q  <= 1'b0;
    end else if (en) begin
      expected_q <= '0;
      seq_err_q  <= 1'b0;
    end else if (pkt_done) begin
      expected_q <= rx_seq + SEQ_W'(1);
      seq_err_q  <= seq_err_q | (rx_seq != expected_q);
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_unpack.sv
// Scoreboard bench for data_unpack: stimulus pushes expected payloads, a monitor pops on each handshake.
module tb_data_unpack;
  import dma_pkt_pkg::*;

  localparam int BEAT_W = 512;
  localparam int BEATS  = 8;
  localparam int TOP_LO = PKT_W - (BEATS - 1) * BEAT_W;
`ifdef DATA_UNPACK_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [7:0]           seq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] rx_num_wire;
  logic       seq_err;
  logic [7:0] frame_err_cnt;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_hs = -1;
  bit   gap_chk = 1'b0;
  int   delivered = 0;
  int   base;

  data_unpack_if #(.BEAT_W(BEAT_W)) bus ();

  data_unpack #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) dut (
    .m_axis_c2h_aclk    (clk),
    .m_axis_c2h_aresetn (rst_n),
    .en                 (en),
    .bus                (bus),
    .rx_num_wire        (rx_num_wire),
    .seq_err            (seq_err),
    .frame_err_cnt      (frame_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Word w of beat k of packet id: {id, k, w, 5A}; beat 0 low byte is the seq number,
  // and the bits of the final beat beyond the packet are filled with ones.
  function automatic logic [BEAT_W-1:0] beat_data(input int id, input int k, input logic [7:0] seq);
    logic [BEAT_W-1:0] d;
    for (int w = 0; w < BEAT_W / 32; w++) d[w*32 +: 32] = {8'(id), 8'(k), 8'(w), 8'h5A};
    if (k == 0) d[7:0] = seq;
    if (k == BEATS - 1) d[BEAT_W-1:TOP_LO] = '1;
    return d;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] pkt_payload(input int id, input logic [7:0] seq);
    logic [BEATS*BEAT_W-1:0] full;
    for (int k = 0; k < BEATS; k++) full[k*BEAT_W +: BEAT_W] = beat_data(id, k, seq);
    return full[PKT_W-1:8];
  endfunction

  task automatic send_beat(input logic [BEAT_W-1:0] d, input bit last);
    bit rdy;
    int n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    forever begin
      rdy = bus.s_axis_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout: tready got 0 for %0d cycles expected 1", n);
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] seq, input int id, input int nbeats, input int last_at, input bit push);
    exp_t e;
    if (push) begin
      e.payload = pkt_payload(id, seq);
      e.seq     = seq;
      exp_q.push_back(e);
    end
    for (int k = 0; k < nbeats; k++) send_beat(beat_data(id, k, seq), (k == last_at));
  endtask

  task automatic pulse_en();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_delivery: got seq %0h expected no packet", rx_num_wire);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.in_io_data !== mon_e.payload || rx_num_wire !== mon_e.seq) begin
          failures++;
          $display("FAIL payload: got seq %0h data[31:0] %0h expected seq %0h data[31:0] %0h",
                   rx_num_wire, bus.in_io_data[31:0], mon_e.seq, mon_e.payload[31:0]);
        end
      end
      delivered++;
      if (gap_chk) begin
        if (last_hs >= 0) chk("packet_period", cyc - last_hs, 9);
        last_hs = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.in_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_in_valid", bus.in_valid, 0);
    chk("rst_in_io_data", {31'b0, |bus.in_io_data}, 0);
    chk("rst_rx_num", rx_num_wire, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_frame_err", frame_err_cnt, 0);
    chk("rst_tready", bus.s_axis_tready, 1);

    // First packet: hand-derived payload edges
    send_pkt(8'h00, 8'h11, 8, 7, 1'b1);
    chk("p1_in_valid", bus.in_valid, 1);
    chk("p1_data_low", bus.in_io_data[31:0], 32'h5A110000);
    chk("p1_data_top", {8'h0, bus.in_io_data[PAYLOAD_W-1:PAYLOAD_W-24]}, 32'h005A1107);
    chk("p1_rx_num", rx_num_wire, 8'h00);
    chk("p1_seq_err", seq_err, 0);
    drain("p1_drain");

    // 300 back-to-back packets with wrap
    pulse_en();
    base = delivered;
    last_hs = -1;
    gap_chk = 1'b1;
    for (int i = 0; i < 300; i++) send_pkt(8'(i), i, 8, 7, 1'b1);
    drain("burst_drain");
    gap_chk = 1'b0;
    chk("burst_count", delivered - base, 300);
    chk("burst_seq_err", seq_err, 0);

    // Sequence gap 0,1,5,6
    pulse_en();
    send_pkt(8'd0, 8'h20, 8, 7, 1'b1);
    send_pkt(8'd1, 8'h21, 8, 7, 1'b1);
    chk("seq_ok_before_gap", seq_err, 0);
    send_pkt(8'd5, 8'h22, 8, 7, 1'b1);
    chk("seq_gap_err", seq_err, 32'(SEQ_ON));
    send_pkt(8'd6, 8'h23, 8, 7, 1'b1);
    chk("seq_err_sticky", seq_err, 32'(SEQ_ON));
    drain("seq_drain");

    // Early tlast on beat 3
    pulse_en();
    base = delivered;
    send_pkt(8'd0, 8'h30, 4, 3, 1'b0);
    chk("early_frame_err", frame_err_cnt, 1);
    chk("early_no_valid", bus.in_valid, 0);
    send_pkt(8'd0, 8'h31, 8, 7, 1'b1);
    drain("early_drain");
    chk("early_count", delivered - base, 1);
    chk("early_frame_err_hold", frame_err_cnt, 1);

    // Missing tlast, two extra beats
    pulse_en();
    base = delivered;
    send_pkt(8'd0, 8'h40, 10, 9, 1'b0);
    chk("drop_frame_err", frame_err_cnt, 1);
    chk("drop_no_valid", bus.in_valid, 0);
    send_pkt(8'd0, 8'h41, 8, 7, 1'b1);
    drain("drop_drain");
    chk("drop_count", delivered - base, 1);

    // Asynchronous reset mid-packet
    send_pkt(8'd1, 8'h50, 3, -1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_frame_err", frame_err_cnt, 0);
    chk("arst_in_valid", bus.in_valid, 0);
    chk("arst_tready", bus.s_axis_tready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pkt(8'd0, 8'h51, 8, 7, 1'b1);
    drain("arst_drain");
    chk("arst_seq_err", seq_err, 0);

    // en coinciding with the last beat discards the packet
    for (int k = 0; k < BEATS - 1; k++) send_beat(beat_data(8'h60, k, 8'd1), 1'b0);
    bus.s_axis_tdata  = beat_data(8'h60, BEATS - 1, 8'd1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    chk("en_last_no_valid", bus.in_valid, 0);
    chk("en_last_tready", bus.s_axis_tready, 1);
    chk("en_last_rx_num", rx_num_wire, 0);
    send_pkt(8'd0, 8'h61, 8, 7, 1'b1);
    drain("en_last_drain");
    chk("en_last_seq_err", seq_err, 0);

    // Backpressure: hold 20 cycles with beats offered, then en
    send_pkt(8'd0, 8'h6F, 2, 1, 1'b0);
    bus.in_ready = 1'b0;
    send_pkt(8'd5, 8'h70, 8, 7, 1'b1);
    chk("hold_in_valid", bus.in_valid, 1);
    chk("hold_seq_err", seq_err, 32'(SEQ_ON));
    bus.s_axis_tdata  = beat_data(8'h71, 0, 8'd2);
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_tready", bus.s_axis_tready, 0);
      checks++;
      if (exp_q.size() == 0 || bus.in_io_data !== exp_q[0].payload || bus.in_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_data: got valid %0b data[31:0] %0h expected valid 1 held payload",
                 bus.in_valid, bus.in_io_data[31:0]);
      end
    end
    bus.s_axis_tvalid = 1'b0;
    pulse_en();
    exp_q.delete();
    chk("en_in_valid", bus.in_valid, 0);
    chk("en_tready", bus.s_axis_tready, 1);
    chk("en_frame_err", frame_err_cnt, 0);
    chk("en_seq_err", seq_err, 0);
    chk("en_rx_num", rx_num_wire, 0);
    chk("en_in_io_data", {31'b0, |bus.in_io_data}, 0);
    bus.in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_unpack.md
# data_unpack

Host-to-card receive unpacker for the DMA bridge, the inverse of the card-to-host packer. It collects a 4072-bit packet from a 512-bit AXI-Stream as eight beats and checks the 8-bit sequence number in bits [7:0] against an internal expected counter. It then presents the 4064-bit payload to the DUT-side input port with a valid/ready handshake. Framing errors (misplaced tlast) are detected and discarded without stalling the stream.

## Interface
- BEAT_W, 512, stream beat width
- BEATS, 8, beats per packet; BEATS*BEAT_W must be at least PKT_W
- m_axis_c2h_aclk  in  1  sole clock
- m_axis_c2h_aresetn  in  1  asynchronous, active-low reset
- en  in  1  synchronous clear; same effect as reset; highest priority below reset
- s_axis_tdata  in  BEAT_W  stream data
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  beat accepted when tvalid && tready
- in_io_data  out  4064  payload, packet bits [4071:8]
- in_valid  out  1  payload valid
- in_ready  in  1  DUT accepts payload
- rx_num_wire  out  8  sequence number of the held/last packet
- seq_err  out  1  sticky sequence-mismatch flag
- frame_err_cnt  out  8  framing-error count, saturates at 255

## Operation
- States: COLLECT, HOLD, DROP. Reset/en state is COLLECT with beat index 0.
- COLLECT: tready=1.
  - Beat k is written to packet bits [k*512 +: 512].
  - On beat 7, only the low 488 bits are kept; bits [511:488] are ignored.
- Framing rules:
  - tlast on beat 7: packet complete; go to HOLD; in_valid=1.
  - tlast on beat k<7: discard the partial packet; frame_err_cnt+1; stay in COLLECT with index 0.
  - No tlast on beat 7: discard; frame_err_cnt+1; go to DROP.
- DROP: tready=1. Discard beats until a beat with tlast is accepted, then go to COLLECT with index 0.
- HOLD: tready=0.
  - in_io_data and rx_num_wire are stable.
  - When in_valid && in_ready, go to COLLECT.
- Sequence check, performed at completion:
  - rx == expected: expected+1, mod 256, wraps 255→0.
  - rx != expected: seq_err←1 (sticky); expected←rx+1 (resync).
  - The packet is still delivered.
- en, including mid-packet or during HOLD:
  - Pending data is lost.
  - expected, seq_err, frame_err_cnt and index are cleared; state goes to COLLECT.

## Timing
- Reset values:
  - in_valid=0, in_io_data=0, rx_num_wire=0, seq_err=0, frame_err_cnt=0, expected=0.
  - s_axis_tready=1 once reset is released (state COLLECT).
- in_valid rises the cycle after the accepted beat-7/tlast beat.
- in_valid falls the cycle after the in_valid && in_ready handshake; tready=1 in that same following cycle.
- Minimum packet period: 9 cycles (8 beats plus 1 handshake cycle with in_ready tied high).
- in_valid and data never change while in_valid=1 and in_ready=0.
- tready is a decode of registered state; no combinational path from in_ready to tready.
- en in the same cycle as a handshake or last beat: en wins, and the packet is neither delivered nor counted.
- Asynchronous reset mid-packet: all state is cleared immediately.

## Configuration
- DATA_UNPACK_SEQ_CHECK_EN defined: expected counter and seq_err are implemented as above.
- Not defined: no expected counter; seq_err is tied to 0; rx_num_wire still reports the received byte.

## Structure
- Shared package dma_pkt_pkg holds PKT_W=4072, PAYLOAD_W=4064, SEQ_W=8, and the state enum. The packer uses the same constants.
- One natural sub-module: dp_beat_assembler.
  - Contains the beat index counter and the packet register write.
  - Reports last-index and tlast mismatch to the parent FSM.

## Test plan
- Reset, then 8 beats with tlast on beat 7 and seq byte 0x00, in_ready=1:
  - in_valid=1 one cycle after beat 7.
  - in_io_data equals packet bits [4071:8]; seq_err=0.
- 300 back-to-back packets with seq 0..255,0..43, in_ready=1:
  - No seq_err.
  - Exactly one packet every 9 cycles.
  - Counter wrap 255→0 is accepted.
- Packets with seq 0,1,5,6:
  - seq_err=1 after the third packet and stays 1.
  - The fourth packet (seq 6) is accepted as in sequence.
- tlast on beat 3, then a clean packet:
  - frame_err_cnt=1; only the clean packet is delivered.
- Beat 7 without tlast, 2 extra beats, tlast on the second:
  - frame_err_cnt=1; DROP is left on tlast; the next packet is delivered.
- Hold in_ready=0 for 20 cycles while stream beats are offered:
  - tready=0 and output data stable throughout.
- Then pulse en:
  - in_valid=0, all counters 0, tready=1 the next cycle.
